// File: rtl/issue_scheduler_nway.sv
// N-lane in-order issue scheduler.
// Holds one fetch bundle, decodes register usage per lane, issues the longest
// hazard-free in-order prefix of the pending lanes each cycle, and inserts
// SPLIT_GAP bubble cycles between the groups of a split bundle.
module issue_scheduler_nway #(
    parameter int ISSUE_WIDTH = 2,
    parameter int XLEN        = 32,
    parameter int SPLIT_GAP   = 1,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        bundle_valid,
    input  logic [ISSUE_WIDTH*XLEN-1:0] instr_in,
    output logic                        bundle_ready,
    output logic [ISSUE_WIDTH-1:0]      issue_valid,
    output logic [ISSUE_WIDTH*XLEN-1:0] issue_instr,
    output logic                        stall,
    output logic                        dep_split,
    output logic [CNT_W-1:0]            split_count
);

    localparam int W = ISSUE_WIDTH;

    // Gap counter reload value; only meaningful when SPLIT_GAP > 0.
    localparam logic [1:0] GAP_RELOAD = (SPLIT_GAP > 0) ? 2'(SPLIT_GAP - 1) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [W-1:0]        r_pending;
    logic [W*XLEN-1:0]   r_instr;
    logic [1:0]          r_gap_cnt;
    logic [CNT_W-1:0]    r_split_count;

    logic [4:0]          w_rd  [W];
    logic [4:0]          w_rs1 [W];
    logic [4:0]          w_rs2 [W];
    logic [W-1:0]        w_rd_use;
    logic [W-1:0]        w_rs1_use;
    logic [W-1:0]        w_rs2_use;
    logic [W-1:0]        w_in_nonzero;
    logic [W-1:0]        w_hazard;
    logic [W-1:0]        w_issue;
    logic                w_can_issue;
    logic                w_all_issue;
    logic                w_load;

    // Per-lane decode of the held instruction; x0 uses are dropped here so the
    // hazard logic never has to special-case register 0.
    for (genvar gi = 0; gi < W; gi++) begin : g_lane
        logic [XLEN-1:0] w_lane;
        logic            w_dec_rd;
        logic            w_dec_rs1;
        logic            w_dec_rs2;

        assign w_lane = r_instr[gi*XLEN +: XLEN];

        // Classify the opcode into which register fields it actually uses.
        always_comb begin
            w_dec_rd  = 1'b0;
            w_dec_rs1 = 1'b0;
            w_dec_rs2 = 1'b0;
            case (w_lane[6:0])
                7'b0110011: begin
                    w_dec_rd  = 1'b1;
                    w_dec_rs1 = 1'b1;
                    w_dec_rs2 = 1'b1;
                end
                7'b0010011, 7'b0000011, 7'b1100111: begin
                    w_dec_rd  = 1'b1;
                    w_dec_rs1 = 1'b1;
                end
                7'b0100011, 7'b1100011: begin
                    w_dec_rs1 = 1'b1;
                    w_dec_rs2 = 1'b1;
                end
                7'b0110111, 7'b0010111, 7'b1101111: begin
                    w_dec_rd  = 1'b1;
                end
                default: ;
            endcase
        end

        assign w_rd[gi]         = w_lane[11:7];
        assign w_rs1[gi]        = w_lane[19:15];
        assign w_rs2[gi]        = w_lane[24:20];
        assign w_rd_use[gi]     = w_dec_rd  & (w_lane[11:7]  != 5'd0);
        assign w_rs1_use[gi]    = w_dec_rs1 & (w_lane[19:15] != 5'd0);
        assign w_rs2_use[gi]    = w_dec_rs2 & (w_lane[24:20] != 5'd0);
        assign w_in_nonzero[gi] = |instr_in[gi*XLEN +: XLEN];
    end

    // A lane is hazarded by any still-pending earlier lane writing a register
    // it reads (RAW) or also writes (WAW); issued-this-cycle lanes are still
    // pending here, so same-cycle conflicts are covered too.
    always_comb begin
        w_hazard = '0;
        for (int j = 1; j < W; j++) begin
            for (int i = 0; i < j; i++) begin
                if (r_pending[i] && w_rd_use[i] &&
                    ((w_rs1_use[j] && (w_rs1[j] == w_rd[i])) ||
                     (w_rs2_use[j] && (w_rs2[j] == w_rd[i])) ||
                     (w_rd_use[j]  && (w_rd[j]  == w_rd[i])))) begin
                    w_hazard[j] = 1'b1;
                end
            end
        end
    end

    assign w_can_issue = en && (r_state == S_ISSUE);

    // Strict in-order selection: the first pending lane that cannot issue
    // blocks every later lane.
    always_comb begin
        logic v_blocked;
        v_blocked = 1'b0;
        w_issue   = '0;
        for (int j = 0; j < W; j++) begin
            w_issue[j] = w_can_issue && r_pending[j] && !w_hazard[j] && !v_blocked;
            if (r_pending[j] && !w_issue[j]) begin
                v_blocked = 1'b1;
            end
        end
    end

    assign w_all_issue  = ((r_pending & ~w_issue) == '0);
    assign bundle_ready = en && ((r_state == S_IDLE) || ((r_state == S_ISSUE) && w_all_issue));
    assign stall        = en && (r_state != S_IDLE) && !bundle_ready;
    assign dep_split    = w_can_issue && !w_all_issue;
    assign w_load       = bundle_valid && bundle_ready;
    assign issue_valid  = w_issue;
    assign issue_instr  = r_instr;
    assign split_count  = r_split_count;

    // Scheduler state machine: load, issue groups, bubble gaps, split counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_instr       <= '0;
            r_gap_cnt     <= 2'd0;
            r_split_count <= '0;
        end else if (en) begin
            if (dep_split && (r_split_count != {CNT_W{1'b1}})) begin
                r_split_count <= r_split_count + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_instr   <= instr_in;
                        r_pending <= w_in_nonzero;
                        r_state   <= (|w_in_nonzero) ? S_ISSUE : S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (w_all_issue) begin
                        if (w_load) begin
                            r_instr   <= instr_in;
                            r_pending <= w_in_nonzero;
                            r_state   <= (|w_in_nonzero) ? S_ISSUE : S_IDLE;
                        end else begin
                            r_pending <= '0;
                            r_state   <= S_IDLE;
                        end
                    end else begin
                        r_pending <= r_pending & ~w_issue;
                        if (SPLIT_GAP > 0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= GAP_RELOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == 2'd0) begin
                        r_state <= S_ISSUE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_scheduler_nway.sv
// Bench for issue_scheduler_nway: accepted bundles are turned into a list of
// expected issue groups by a register-set reference model; a monitor walks
// that list cycle by cycle and compares the DUT outputs.
module tb_issue_scheduler_nway;

    localparam int W     = 4;
    localparam int XLEN  = 32;
    localparam int GAP   = 1;
    localparam int CNT_W = 16;
    localparam int BW    = W * XLEN;

    logic              clk;
    logic              rst;
    logic              en;
    logic              bundle_valid;
    logic [BW-1:0]     instr_in;
    logic              bundle_ready;
    logic [W-1:0]      issue_valid;
    logic [BW-1:0]     issue_instr;
    logic              stall;
    logic              dep_split;
    logic [CNT_W-1:0]  split_count;

    issue_scheduler_nway #(
        .ISSUE_WIDTH(W),
        .XLEN(XLEN),
        .SPLIT_GAP(GAP),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .bundle_valid(bundle_valid),
        .instr_in(instr_in),
        .bundle_ready(bundle_ready),
        .issue_valid(issue_valid),
        .issue_instr(issue_instr),
        .stall(stall),
        .dep_split(dep_split),
        .split_count(split_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  mask;
        logic [BW-1:0] instrs;
        bit            last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_splits = 0;
    int   gap_left = 0;

    logic [6:0] opcs [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                              7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                              7'b1101111, 7'b0001111, 7'b1110011};

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register usage straight from the opcode table; 0 means "no register".
    function automatic void decode(input logic [31:0] ins, output int rd, output int rs1, output int rs2);
        int f_rd, f_rs1, f_rs2;
        f_rd  = int'(ins[11:7]);
        f_rs1 = int'(ins[19:15]);
        f_rs2 = int'(ins[24:20]);
        rd = 0; rs1 = 0; rs2 = 0;
        case (ins[6:0])
            7'b0110011:                         begin rd = f_rd; rs1 = f_rs1; rs2 = f_rs2; end
            7'b0010011, 7'b0000011, 7'b1100111: begin rd = f_rd; rs1 = f_rs1; end
            7'b0100011, 7'b1100011:             begin rs1 = f_rs1; rs2 = f_rs2; end
            7'b0110111, 7'b0010111, 7'b1101111: begin rd = f_rd; end
            default: ;
        endcase
    endfunction

    // Split a bundle into in-order issue groups and queue them.
    function automatic void model_push(input logic [BW-1:0] b);
        bit pend[W];
        int rd[W], rs1[W], rs2[W];
        int left;
        left = 0;
        for (int i = 0; i < W; i++) begin
            pend[i] = (b[i*XLEN +: XLEN] != '0);
            decode(b[i*XLEN +: XLEN], rd[i], rs1[i], rs2[i]);
            if (pend[i]) left++;
        end
        while (left > 0) begin
            exp_t e;
            bit stop;
            stop = 0;
            e.mask = '0;
            e.instrs = b;
            for (int j = 0; j < W; j++) begin
                if (pend[j] && !stop) begin
                    bit conflict;
                    conflict = 0;
                    for (int i = 0; i < j; i++) begin
                        if (pend[i] && rd[i] != 0 &&
                            (rd[i] == rs1[j] || rd[i] == rs2[j] || rd[i] == rd[j]))
                            conflict = 1;
                    end
                    if (conflict) stop = 1;
                    else e.mask[j] = 1'b1;
                end
            end
            for (int j = 0; j < W; j++) begin
                if (e.mask[j]) begin
                    pend[j] = 0;
                    left--;
                end
            end
            e.last = (left == 0);
            q.push_back(e);
        end
    endfunction

    // Scoreboard input side: record every bundle the DUT accepts at this edge.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else if (en && bundle_valid && bundle_ready) begin
            model_push(instr_in);
        end
    end

    // Monitor: every enabled cycle is either idle, a bubble, or the next group.
    always @(negedge clk) begin
        if (rst) begin
            gap_left = 0;
            model_splits = 0;
        end else begin
            chk("split_count", BW'(split_count), BW'(model_splits));
            if (!en) begin
                chk("dis_valid", BW'(issue_valid), '0);
                chk("dis_ready", BW'(bundle_ready), '0);
                chk("dis_split", BW'(dep_split), '0);
                chk("dis_stall", BW'(stall), '0);
            end else if (q.size() == 0) begin
                chk("idle_valid", BW'(issue_valid), '0);
                chk("idle_ready", BW'(bundle_ready), BW'(1));
                chk("idle_stall", BW'(stall), '0);
                chk("idle_split", BW'(dep_split), '0);
            end else if (gap_left > 0) begin
                chk("gap_valid", BW'(issue_valid), '0);
                chk("gap_ready", BW'(bundle_ready), '0);
                chk("gap_stall", BW'(stall), BW'(1));
                gap_left--;
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("issue mask=%b last=%0d dut_mask=%b", e.mask, e.last, issue_valid);
                chk("issue_valid", BW'(issue_valid), BW'(e.mask));
                chk("issue_instr", issue_instr, e.instrs);
                chk("dep_split", BW'(dep_split), BW'(!e.last));
                chk("issue_ready", BW'(bundle_ready), BW'(e.last));
                chk("issue_stall", BW'(stall), BW'(!e.last));
                if (!e.last) begin
                    if (model_splits < (2**CNT_W - 1)) model_splits++;
                    gap_left = GAP;
                end
            end
        end
    end

    function automatic logic [31:0] enc(input logic [6:0] opc, input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), opc};
    endfunction

    function automatic logic [31:0] rand_instr();
        if ($urandom_range(0, 15) == 0) return 32'h0;
        return enc(opcs[$urandom_range(0, 10)], $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    // Present a bundle until it is accepted (bounded), then drop valid.
    task automatic send(input logic [BW-1:0] b);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        bundle_valid = 1'b1;
        instr_in = b;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = en && bundle_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: bundle %0h not accepted after %0d cycles", b, n);
        end
        $display("bundle sent %0h", b);
        bundle_valid = 1'b0;
    endtask

    logic [6:0] R, OPI, ST;

    initial begin
        R = 7'b0110011; OPI = 7'b0010011; ST = 7'b0100011;
        rst = 1'b1; en = 1'b1; bundle_valid = 1'b0; instr_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // independent pair
        send({32'h0, 32'h0, enc(R, 4, 5, 6), enc(R, 1, 2, 3)});
        // RAW pair -> split
        send({32'h0, 32'h0, enc(R, 4, 1, 5), enc(R, 1, 2, 3)});
        // chain with two splits
        send({enc(ST, 0, 9, 3), enc(OPI, 3, 4, 0), enc(R, 2, 1, 0), enc(OPI, 1, 5, 0)});
        // x0 destinations ignored, then WAW on x7
        send({enc(OPI, 7, 2, 0), enc(OPI, 7, 1, 0), enc(R, 0, 0, 0), enc(OPI, 0, 1, 0)});
        // NOP lanes and an all-NOP bundle
        send({32'h0, enc(R, 8, 9, 10), 32'h0, enc(R, 1, 2, 3)});
        send('0);
        repeat (6) @(posedge clk);
        #1;
        // reset in the middle of a split
        send({enc(R, 2, 1, 1), enc(R, 1, 2, 3), enc(R, 3, 1, 2), enc(R, 1, 4, 4)});
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // randomized traffic with enable and reset noise
        for (int c = 0; c < 3000; c++) begin
            logic [BW-1:0] b;
            for (int l = 0; l < W; l++) b[l*XLEN +: XLEN] = rand_instr();
            en = ($urandom_range(0, 9) != 0);
            bundle_valid = ($urandom_range(0, 9) < 7);
            instr_in = b;
            rst = ($urandom_range(0, 399) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; en = 1'b1; bundle_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("drain", BW'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
